// File: rtl/serial_sub_if.sv
// rtl/serial_sub_if.sv - start/operand/result bundle for the bit-serial subtractor
interface serial_sub_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial unsigned subtractor, one full-subtractor cell, LSB first
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  serial_sub_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_r;
  logic [WIDTH-1:0] diff_q;
  logic             br;
  logic             borrow_q;
  logic [CW-1:0]    cnt;

  logic x, y, d, br_next;

  always_comb begin
    x       = sh_a[0];
    y       = sh_b[0];
    d       = x ^ y ^ br;
    br_next = (~x & y) | (~x & br) | (y & br);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sh_a     <= '0;
      sh_b     <= '0;
      sh_r     <= '0;
      diff_q   <= '0;
      br       <= 1'b0;
      borrow_q <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sh_a  <= bus.a;
            sh_b  <= bus.b;
            br    <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          sh_r <= {d, sh_r[WIDTH-1:1]};
          br   <= br_next;
          cnt  <= cnt + 1'b1;
          // The last bit is folded in here so diff never sees a partial result.
          if (cnt == LAST) begin
            diff_q   <= {d, sh_r[WIDTH-1:1]};
            borrow_q <= br_next;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and set the operand width; legal range 2..32.
REQ-002 clk, input, 1 bit: the single clock; all state SHALL change only on its rising edge.
REQ-003 rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 start, input, 1 bit: request to begin one subtraction; it SHALL be sampled only in IDLE.
REQ-005 a, input, WIDTH bits: minuend; sampled on the edge at which start is accepted.
REQ-006 b, input, WIDTH bits: subtrahend; sampled on the same edge as a.
REQ-007 busy, output, 1 bit: high while the operation is in progress (RUN state).
REQ-008 done, output, 1 bit: single-cycle pulse marking the cycle in which the result becomes valid.
REQ-009 diff, output, WIDTH bits: registered result, a - b modulo 2^WIDTH.
REQ-010 borrow_out, output, 1 bit: registered final borrow; 1 when a < b (unsigned).

Function
REQ-011 The block SHALL be a bit-serial subtractor with one full-subtractor cell, processing one bit per clock, LSB first.
REQ-012 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-013 IDLE with start=1 SHALL perform all of the following on that edge, then go to RUN:
- latch a into the A shift register and b into the B shift register;
- clear the internal borrow flop;
- clear the bit counter.
REQ-014 In IDLE, start=0 SHALL keep the block in IDLE.
REQ-015 Each RUN cycle SHALL compute, from the current LSBs x=A[0], y=B[0] and borrow br:
- d = x^y^br;
- br_next = (~x&y) | (~x&br) | (y&br).
REQ-016 On the same RUN edge the block SHALL:
- shift A and B right by one;
- shift d into the MSB of the result shift register;
- load br_next into the borrow flop;
- increment the counter.
REQ-017 RUN SHALL last exactly WIDTH cycles. On the edge that processes bit WIDTH-1 the block SHALL:
- copy the complete result into diff;
- copy br_next into borrow_out;
- go to DONE.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-019 Latency: if start is accepted at edge k, done SHALL be high in the cycle between edges k+WIDTH and k+WIDTH+1.
REQ-020 busy SHALL be 1 exactly in the WIDTH RUN cycles and 0 in IDLE and DONE; busy and done SHALL never be high together.
REQ-021 start asserted in RUN or DONE SHALL be ignored and SHALL NOT be queued. A new start is accepted only in IDLE, so the minimum issue interval is WIDTH+2 cycles.
REQ-022 diff and borrow_out SHALL change only at completion (REQ-017) and SHALL hold their values through IDLE and any subsequent RUN until the next completion.
REQ-023 a and b SHALL be don't-care except on the accepting edge; changes to them during RUN SHALL NOT affect the result.
REQ-024 Arithmetic SHALL be unsigned with wrap-around: diff = (a - b) mod 2^WIDTH and borrow_out = (a < b). No other result is permitted.
REQ-025 The counter SHALL be ceil(log2(WIDTH))+1 bits wide or larger and SHALL NOT wrap within RUN.

Reset
REQ-026 rst=1 SHALL take priority over all other inputs on any edge, in any state, and SHALL force:
- state to IDLE;
- busy=0, done=0, diff=0, borrow_out=0;
- internal borrow, counter and shift registers to 0.
REQ-027 rst asserted mid-RUN SHALL abort the operation. No done pulse SHALL follow it, and the partial result SHALL NOT reach diff.
REQ-028 When rst=1 and start=1 occur on the same edge, reset SHALL win. The first start is accepted no earlier than the first edge with rst=0.

Verification (WIDTH=8)
REQ-029 Basic subtract, no borrow: a=0x5A, b=0x23, start for one cycle -> busy for 8 cycles, then done for one cycle, diff=0x37, borrow_out=0.
REQ-030 Underflow: a=0x00, b=0x01 -> diff=0xFF, borrow_out=1. Also a=0x10, b=0x80 -> diff=0x90, borrow_out=1.
REQ-031 Equal operands: a=0xFF, b=0xFF -> diff=0x00, borrow_out=0.
REQ-032 Ignored inputs:
- start pulse at RUN cycle 3 and during the DONE cycle -> exactly one done pulse, result unchanged;
- a and b changed during RUN -> result unchanged.
REQ-033 Reset mid-operation:
- start a=0x5A, b=0x23, then rst at RUN cycle 4 -> all outputs 0, no done pulse;
- next start a=0x05, b=0x07 -> diff=0xFE, borrow_out=1.
REQ-034 Randomized check: 1000 random (a, b) pairs with random start gaps -> every done matches (a - b) mod 256 and (a < b), and each done falls exactly 8 cycles after its accepted start.
